// File: rtl/pn_seq_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | pn_seq_ctrl_if : command and generator-side bundle of the PN sequencer     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pn_seq_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div_ratio;
    logic [9:0]       phase_ofs;
    logic [CNT_W-1:0] period_num;
    logic             pn_allone;
    logic             gen_reset;
    logic             pnclk;
    logic             busy;
    logic             aligned;
    logic             epoch;
    logic             done;
    logic             sync_err;
    logic [CNT_W-1:0] period_cnt;

    modport master (
        output start, stop, div_ratio, phase_ofs, period_num, pn_allone,
        input  gen_reset, pnclk, busy, aligned, epoch, done, sync_err, period_cnt
    );

    modport slave (
        input  start, stop, div_ratio, phase_ofs, period_num, pn_allone,
        output gen_reset, pnclk, busy, aligned, epoch, done, sync_err, period_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pn_seq_ctrl.sv
// +----------------------------------------------------------------------------+
// | pn_seq_ctrl : parks, clocks, phase-slews and period-checks a 1023-chip     |
// | PN generator. Rev 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module pn_seq_ctrl #(
    parameter int PN_LEN  = 1023,
    parameter int DIV_W   = 16,
    parameter int CNT_W   = 16,
    parameter int ARM_CYC = 2,
    parameter int SETTLE  = 3
) (
    input wire           sysclk,
    input wire           reset,
    pn_seq_ctrl_if.slave bus
);
    localparam int       SEQ_W  = 4;
    localparam logic [9:0] C_LAST = 10'(PN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SLEW   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] half_q, half_d, div_cnt_q, div_cnt_d;
    logic [9:0]       phase_q, phase_d, chip_cnt_q, chip_cnt_d;
    logic [CNT_W-1:0] num_q, num_d, period_cnt_q, period_cnt_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [2:0]       tmr_q, tmr_d;
    logic             pnclk_q, pnclk_d, epoch_q, epoch_d, done_q, done_d;
    logic             sync_err_q, sync_err_d;
    logic             gen_reset_q, busy_q, aligned_q;
    logic [9:0]       chip_inc;

    assign chip_inc = (chip_cnt_q == C_LAST) ? 10'd0 : chip_cnt_q + 10'd1;

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        div_cnt_d    = div_cnt_q;
        phase_d      = phase_q;
        chip_cnt_d   = chip_cnt_q;
        num_d        = num_q;
        period_cnt_d = period_cnt_q;
        seq_cnt_d    = seq_cnt_q;
        tmr_d        = 3'd0;
        pnclk_d      = pnclk_q;
        epoch_d      = 1'b0;
        done_d       = 1'b0;
        sync_err_d   = sync_err_q;

        case (state_q)
            S_IDLE: begin
                pnclk_d = 1'b0;
                if (bus.start) begin
                    state_d      = S_ARM;
                    half_d       = (bus.div_ratio < DIV_W'(2)) ? DIV_W'(2) : bus.div_ratio;
                    phase_d      = (bus.phase_ofs > C_LAST) ? C_LAST : bus.phase_ofs;
                    num_d        = bus.period_num;
                    sync_err_d   = 1'b0;
                    period_cnt_d = '0;
                    chip_cnt_d   = '0;
                    div_cnt_d    = '0;
                    seq_cnt_d    = '0;
                end
            end
            S_ARM: begin
                if (seq_cnt_q == SEQ_W'(ARM_CYC - 1)) begin
                    div_cnt_d = '0;
                    if (phase_q != 10'd0) begin
                        // First slew edge lands right as ARM ends.
                        state_d    = S_SLEW;
                        pnclk_d    = 1'b1;
                        chip_cnt_d = chip_inc;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            S_SLEW: begin
                if (pnclk_q) begin
                    pnclk_d = 1'b0;
                    if (chip_cnt_q == phase_q) begin
                        state_d   = S_SETTLE;
                        seq_cnt_d = '0;
                    end
                end else begin
                    pnclk_d    = 1'b1;
                    chip_cnt_d = chip_inc;
                end
            end
            S_SETTLE: begin
                if (seq_cnt_q == SEQ_W'(SETTLE - 1)) begin
                    state_d   = S_RUN;
                    div_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            S_RUN: begin
                if (div_cnt_q == half_q - DIV_W'(1)) begin
                    div_cnt_d = '0;
                    pnclk_d   = ~pnclk_q;
                    if (!pnclk_q) begin
                        chip_cnt_d = chip_inc;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
                if (tmr_q != 3'd0) begin
                    tmr_d = tmr_q - 3'd1;
                end
                // Code wrap: give the generator's flag time to settle before sampling.
                if (div_cnt_q == half_q - DIV_W'(1) && !pnclk_q && chip_cnt_q == C_LAST) begin
                    tmr_d = 3'd4;
                end
                if (tmr_q == 3'd1) begin
                    epoch_d      = 1'b1;
                    period_cnt_d = (&period_cnt_q) ? period_cnt_q : period_cnt_q + CNT_W'(1);
                    if (!bus.pn_allone) begin
                        sync_err_d = 1'b1;
                    end
                end
                if (epoch_q && num_q != '0 && period_cnt_q == num_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pnclk_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pnclk_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                pnclk_d = 1'b0;
            end
        endcase

        // Abort wins over everything, but keeps the run's results visible.
        if (bus.stop) begin
            state_d      = S_IDLE;
            pnclk_d      = 1'b0;
            epoch_d      = 1'b0;
            done_d       = 1'b0;
            tmr_d        = 3'd0;
            period_cnt_d = period_cnt_q;
            sync_err_d   = sync_err_q;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            half_q       <= DIV_W'(2);
            div_cnt_q    <= '0;
            phase_q      <= '0;
            chip_cnt_q   <= '0;
            num_q        <= '0;
            period_cnt_q <= '0;
            seq_cnt_q    <= '0;
            tmr_q        <= 3'd0;
            pnclk_q      <= 1'b0;
            epoch_q      <= 1'b0;
            done_q       <= 1'b0;
            sync_err_q   <= 1'b0;
            gen_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            aligned_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            div_cnt_q    <= div_cnt_d;
            phase_q      <= phase_d;
            chip_cnt_q   <= chip_cnt_d;
            num_q        <= num_d;
            period_cnt_q <= period_cnt_d;
            seq_cnt_q    <= seq_cnt_d;
            tmr_q        <= tmr_d;
            pnclk_q      <= pnclk_d;
            epoch_q      <= epoch_d;
            done_q       <= done_d;
            sync_err_q   <= sync_err_d;
            gen_reset_q  <= (state_d == S_IDLE);
            busy_q       <= (state_d != S_IDLE);
            aligned_q    <= (state_d == S_RUN);
        end
    end

    assign bus.gen_reset  = gen_reset_q;
    assign bus.pnclk      = pnclk_q;
    assign bus.busy       = busy_q;
    assign bus.aligned    = aligned_q;
    assign bus.epoch      = epoch_q;
    assign bus.done       = done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.period_cnt = period_cnt_q;

endmodule

`default_nettype wire
